// File: rtl/qnet_dbg_pkg.sv
// qnet_dbg_pkg
//   Shared types and constants for the QNET command-debug trace buffer.
//   - type_trace_st_t : trace capture state, encoding visible on st_o
//   - CODE_*          : well-known command state codes
//   - trace_entry_t   : layout of one trace entry at the default
//                       timestamp width, {code, ts}, as it appears in
//                       rd_dt_o[29:0]
package qnet_dbg_pkg;

    localparam int unsigned CODE_W    = 6;
    localparam int unsigned TS_W_DFLT = 24;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_POST    = 2'd2,
        ST_DONE    = 2'd3
    } type_trace_st_t;

    localparam logic [CODE_W-1:0] CODE_NOT_READY = 6'd0;
    localparam logic [CODE_W-1:0] CODE_IDLE      = 6'd1;
    localparam logic [CODE_W-1:0] CODE_ST_ERROR  = 6'd63;

    typedef struct packed {
        logic [CODE_W-1:0]    code;
        logic [TS_W_DFLT-1:0] ts;
    } trace_entry_t;

endpackage

// File: rtl/qnet_dbg_trace_ram.sv
// qnet_dbg_trace_ram
//   Simple dual-port trace storage, 2**AW x DW. One synchronous write
//   port and one registered read port; a read of the address being
//   written in the same cycle returns the old contents. Not reset.
// Ports:
//   st_clk_i  in   clock
//   wr_en     in   write enable
//   wr_addr   in   write address
//   wr_data   in   write data
//   rd_addr   in   read address
//   rd_data   out  registered read data (1-cycle latency)
module qnet_dbg_trace_ram #(
    parameter int unsigned AW = 4,
    parameter int unsigned DW = 30
) (
    input  logic          st_clk_i,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge st_clk_i) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/qnet_dbg_trace.sv
// qnet_dbg_trace
//   Trace buffer for the 32-bit command-state debug word. Every change of
//   the word while capturing stores {newest code, timestamp} into a
//   circular buffer; capture stops POST_TRIG entries after a trigger code.
//   Entries are read back oldest-first.
// Build option:
//   QNET_DBG_TS_DELTA_EN  defined   : ts = cycles since previous stored
//                                     entry (or since arm), saturating
//                         undefined : ts = absolute free-running counter
// Ports:
//   st_clk_i     in   clock
//   st_rst_ni    in   asynchronous active-low reset
//   debug_dt_i   in   packed state history, newest code in [29:24]
//   arm_i        in   pulse: clear trace and start capture
//   trig_en_i    in   enable trigger matching
//   trig_code_i  in   trigger state code
//   rd_idx_i     in   read index, 0 = oldest valid entry
//   rd_dt_o      out  {2'b0, code, ts}, 1 cycle after rd_idx_i
//   cnt_o        out  number of valid entries
//   wrap_o       out  old entries have been overwritten
//   trig_o       out  trigger entry captured
//   st_o         out  0 IDLE, 1 CAPTURE, 2 POST, 3 DONE
module qnet_dbg_trace
    import qnet_dbg_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned TS_W       = 24,
    parameter int unsigned POST_TRIG  = 4
) (
    input  logic                  st_clk_i,
    input  logic                  st_rst_ni,
    input  logic [31:0]           debug_dt_i,
    input  logic                  arm_i,
    input  logic                  trig_en_i,
    input  logic [5:0]            trig_code_i,
    input  logic [DEPTH_LOG2-1:0] rd_idx_i,
    output logic [31:0]           rd_dt_o,
    output logic [DEPTH_LOG2:0]   cnt_o,
    output logic                  wrap_o,
    output logic                  trig_o,
    output logic [1:0]            st_o
);

    localparam int unsigned           DEPTH     = 2**DEPTH_LOG2;
    localparam int unsigned           ENT_W     = CODE_W + TS_W;
    localparam logic [DEPTH_LOG2:0]   CNT_FULL  = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2-1:0] POST_LOAD = DEPTH_LOG2'(POST_TRIG);

    type_trace_st_t        st_q, st_nxt;
    logic [29:0]           prev_q;
    logic [CODE_W-1:0]     new_code;
    logic                  chg, cap_st, wr_en, trig_hit;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, post_cnt_q, rd_addr;
    logic [DEPTH_LOG2:0]   cnt_q;
    logic                  wrap_q, trig_q, rd_vld_q;
    logic [TS_W-1:0]       ts_wr;
    logic [ENT_W-1:0]      wr_data, rd_data;
    logic                  unused_rsvd;

    // Bits [31:30] are reserved (always 0 upstream) and take no part in
    // change detection.
    assign unused_rsvd = ^debug_dt_i[31:30];

    assign new_code = debug_dt_i[29:24];
    assign chg      = (debug_dt_i[29:0] != prev_q);
    assign cap_st   = (st_q == ST_CAPTURE) || (st_q == ST_POST);
    // arm_i wins over a coincident change: that change is dropped.
    assign wr_en    = chg && cap_st && !arm_i;
    assign trig_hit = wr_en && (st_q == ST_CAPTURE) && trig_en_i
                      && (new_code == trig_code_i);

    // ------------------------------------------------------------------
    // Timestamp source
    // ------------------------------------------------------------------
`ifdef QNET_DBG_TS_DELTA_EN
    logic [TS_W-1:0] dlt_q;

    // Reloaded to 1 at the arm/write edge so that the value seen at a
    // later write edge equals the number of cycles in between.
    always_ff @(posedge st_clk_i or negedge st_rst_ni) begin
        if (!st_rst_ni) begin
            dlt_q <= '0;
        end else if (arm_i || wr_en) begin
            dlt_q <= TS_W'(1);
        end else if (dlt_q != '1) begin
            dlt_q <= dlt_q + 1'b1;
        end
    end

    assign ts_wr = dlt_q;
`else
    logic [TS_W-1:0] ts_q;

    always_ff @(posedge st_clk_i or negedge st_rst_ni) begin
        if (!st_rst_ni) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + 1'b1;
        end
    end

    assign ts_wr = ts_q;
`endif

    // ------------------------------------------------------------------
    // Capture FSM
    // ------------------------------------------------------------------
    always_ff @(posedge st_clk_i or negedge st_rst_ni) begin
        if (!st_rst_ni) begin
            st_q <= ST_IDLE;
        end else begin
            st_q <= st_nxt;
        end
    end

    always_comb begin
        st_nxt = st_q;
        if (arm_i) begin
            st_nxt = ST_CAPTURE;
        end else begin
            unique case (st_q)
                ST_CAPTURE: begin
                    if (trig_hit) begin
                        st_nxt = (POST_TRIG == 0) ? ST_DONE : ST_POST;
                    end
                end
                ST_POST: begin
                    if (wr_en && (post_cnt_q == DEPTH_LOG2'(1))) begin
                        st_nxt = ST_DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Write pointer, occupancy and flags
    // ------------------------------------------------------------------
    always_ff @(posedge st_clk_i or negedge st_rst_ni) begin
        if (!st_rst_ni) begin
            prev_q     <= '0;
            wr_ptr_q   <= '0;
            cnt_q      <= '0;
            wrap_q     <= 1'b0;
            trig_q     <= 1'b0;
            post_cnt_q <= '0;
            rd_vld_q   <= 1'b0;
        end else begin
            prev_q   <= debug_dt_i[29:0];
            rd_vld_q <= ({1'b0, rd_idx_i} < cnt_q);
            if (arm_i) begin
                wr_ptr_q <= '0;
                cnt_q    <= '0;
                wrap_q   <= 1'b0;
                trig_q   <= 1'b0;
            end else if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
                if (cnt_q == CNT_FULL) begin
                    wrap_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
                if (trig_hit) begin
                    trig_q     <= 1'b1;
                    post_cnt_q <= POST_LOAD;
                end else if (st_q == ST_POST) begin
                    post_cnt_q <= post_cnt_q - 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Storage and read-back
    // ------------------------------------------------------------------
    assign wr_data = {new_code, ts_wr};

    // Once wrapped, the oldest entry sits at the write pointer.
    assign rd_addr = wrap_q ? (wr_ptr_q + rd_idx_i) : rd_idx_i;

    qnet_dbg_trace_ram #(
        .AW (DEPTH_LOG2),
        .DW (ENT_W)
    ) u_ram (
        .st_clk_i (st_clk_i),
        .wr_en    (wr_en),
        .wr_addr  (wr_ptr_q),
        .wr_data  (wr_data),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data)
    );

    // The RAM output is not reset; the registered valid bit both blanks
    // out-of-range indices and forces 0 immediately on reset.
    assign rd_dt_o = rd_vld_q ? 32'(rd_data) : '0;
    assign cnt_o   = cnt_q;
    assign wrap_o  = wrap_q;
    assign trig_o  = trig_q;
    assign st_o    = st_q;

endmodule

// File: tb/tb_qnet_dbg_trace.sv
// tb_qnet_dbg_trace
//   Directed bench for qnet_dbg_trace. Two instances share all inputs:
//   u_dut with POST_TRIG=4 and u_dut0 with POST_TRIG=0.
//   Inputs change on the falling edge; outputs are checked there too.
//   Expected timestamps follow from the cycle count: a change driven
//   after the n-th rising edge since reset release is stored with ts=n.
module tb_qnet_dbg_trace;
    import qnet_dbg_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] dt;
    logic        arm;
    logic        trig_en;
    logic [5:0]  trig_code;
    logic [3:0]  rd_idx;

    logic [31:0] rd_dt,  rd_dt0;
    logic [4:0]  cnt,    cnt0;
    logic        wrap,   wrap0;
    logic        trig,   trig0;
    logic [1:0]  st,     st0;

    int unsigned cyc      = 0;
    int unsigned last_cyc = 0;
    int unsigned checks   = 0;
    int unsigned passes   = 0;

    logic [23:0]  t1 [4];
    logic [23:0]  t_tmp, t63, t5, t_d1, t_d2;
    trace_entry_t ent;

    always #5 clk = ~clk;

    qnet_dbg_trace #(
        .DEPTH_LOG2 (4),
        .TS_W       (24),
        .POST_TRIG  (4)
    ) u_dut (
        .st_clk_i    (clk),
        .st_rst_ni   (rst_n),
        .debug_dt_i  (dt),
        .arm_i       (arm),
        .trig_en_i   (trig_en),
        .trig_code_i (trig_code),
        .rd_idx_i    (rd_idx),
        .rd_dt_o     (rd_dt),
        .cnt_o       (cnt),
        .wrap_o      (wrap),
        .trig_o      (trig),
        .st_o        (st)
    );

    qnet_dbg_trace #(
        .DEPTH_LOG2 (4),
        .TS_W       (24),
        .POST_TRIG  (0)
    ) u_dut0 (
        .st_clk_i    (clk),
        .st_rst_ni   (rst_n),
        .debug_dt_i  (dt),
        .arm_i       (arm),
        .trig_en_i   (trig_en),
        .trig_code_i (trig_code),
        .rd_idx_i    (rd_idx),
        .rd_dt_o     (rd_dt0),
        .cnt_o       (cnt0),
        .wrap_o      (wrap0),
        .trig_o      (trig0),
        .st_o        (st0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic tick_to(input int unsigned c);
        while (cyc < c) tick();
    endtask

    // Shift a new newest code into the history word; return its expected ts.
    task automatic push(input logic [5:0] code, output logic [23:0] t);
        dt = {2'b00, code, dt[29:6]};
`ifdef QNET_DBG_TS_DELTA_EN
        t = 24'(cyc - last_cyc);
`else
        t = 24'(cyc);
`endif
        last_cyc = cyc;
    endtask

    task automatic do_arm();
        arm      = 1'b1;
        last_cyc = cyc;
        tick();
        arm = 1'b0;
    endtask

    initial begin
        dt        = {2'b00, 6'd0, 6'd62, 6'd62, 6'd62, 6'd62};
        arm       = 1'b0;
        trig_en   = 1'b0;
        trig_code = 6'd0;
        rd_idx    = 4'd0;
        rst_n     = 1'b1;
        #1 rst_n  = 1'b0;
        #3;
        chk("rst_rd_dt", rd_dt, 32'h0);
        chk("rst_cnt",   32'(cnt), 32'd0);
        chk("rst_wrap",  32'(wrap), 32'd0);
        chk("rst_trig",  32'(trig), 32'd0);
        chk("rst_st",    32'(st), 32'(ST_IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;

        // ---- basic capture: codes 1,2,13,1 at cycles 10,20,35,50 ----
        tick_to(2);
        do_arm();
        chk("t1_st_capture", 32'(st), 32'(ST_CAPTURE));
        chk("t1_cnt0", 32'(cnt), 32'd0);
        tick_to(10); push(6'd1,  t1[0]); tick();
        tick_to(20); push(6'd2,  t1[1]); tick();
        tick_to(35); push(6'd13, t1[2]); tick();
        tick_to(50); push(6'd1,  t1[3]); tick();
        tick();
        chk("t1_cnt4", 32'(cnt), 32'd4);
        chk("t1_wrap0", 32'(wrap), 32'd0);
`ifndef QNET_DBG_TS_DELTA_EN
        chk("t1_ts0_abs", 32'(t1[0]), 32'd10);
`endif
        rd_idx = 4'd0; tick(); chk("t1_rd0", rd_dt, {2'b00, 6'd1,  t1[0]});
        rd_idx = 4'd1; tick(); chk("t1_rd1", rd_dt, {2'b00, 6'd2,  t1[1]});
        rd_idx = 4'd2; tick(); chk("t1_rd2", rd_dt, {2'b00, 6'd13, t1[2]});
        rd_idx = 4'd3; tick(); chk("t1_rd3", rd_dt, {2'b00, 6'd1,  t1[3]});
        rd_idx = 4'd4; tick(); chk("t1_rd_oob", rd_dt, 32'h0);

        // ---- trigger with wrap: 19 codes, then 63, then 4 post entries ----
        trig_en   = 1'b1;
        trig_code = CODE_ST_ERROR;
        do_arm();
        chk("t2_cnt_clear", 32'(cnt), 32'd0);
        for (int i = 0; i < 19; i++) begin
            push(6'(i + 2), t_tmp);
            tick();
        end
        chk("t2_no_trig_yet", 32'(trig), 32'd0);
        push(6'd63, t63); tick();
        chk("t2_st_post", 32'(st), 32'(ST_POST));
        chk("t2_trig_set", 32'(trig), 32'd1);
        for (int i = 0; i < 4; i++) begin
            push(6'(21 + i), t_tmp);
            tick();
            if (i < 3) chk("t2_still_post", 32'(st), 32'(ST_POST));
        end
        chk("t2_st_done", 32'(st), 32'(ST_DONE));
        chk("t2_wrap", 32'(wrap), 32'd1);
        chk("t2_cnt_full", 32'(cnt), 32'd16);
        push(6'd40, t_tmp); tick();
        chk("t2_done_hold_cnt", 32'(cnt), 32'd16);
        chk("t2_done_hold_st", 32'(st), 32'(ST_DONE));
        rd_idx = 4'd0; tick();
        ent = trace_entry_t'(rd_dt[29:0]);
        chk("t2_oldest_code", 32'(ent.code), 32'd10);
        rd_idx = 4'd11; tick();
        chk("t2_idx11", rd_dt, {2'b00, 6'd63, t63});
        rd_idx = 4'd15; tick();
        ent = trace_entry_t'(rd_dt[29:0]);
        chk("t2_newest_code", 32'(ent.code), 32'd24);

        // ---- POST_TRIG=0: trigger on the first entry ----
        trig_code = 6'd5;
        do_arm();
        push(6'd5, t5); tick();
        chk("t3_dut0_done", 32'(st0), 32'(ST_DONE));
        chk("t3_dut0_cnt1", 32'(cnt0), 32'd1);
        chk("t3_dut0_trig", 32'(trig0), 32'd1);
        chk("t3_dut_post", 32'(st), 32'(ST_POST));
        push(6'd6, t_tmp); tick();
        push(6'd7, t_tmp); tick();
        chk("t3_dut0_ignored", 32'(cnt0), 32'd1);
        rd_idx = 4'd0; tick();
        chk("t3_dut0_rd0", rd_dt0, {2'b00, 6'd5, t5});

        // ---- constant word, and change coincident with arm ----
        trig_en = 1'b0;
        do_arm();
        push(6'd9, t_tmp); tick();
        chk("t4_cnt1", 32'(cnt), 32'd1);
        repeat (100) tick();
        chk("t4_hold_cnt", 32'(cnt), 32'd1);
        arm = 1'b1;
        push(6'd11, t_tmp);
        tick();
        arm = 1'b0;
        chk("t4_arm_chg_cnt", 32'(cnt), 32'd0);
        chk("t4_arm_st", 32'(st), 32'(ST_CAPTURE));
        tick();
        chk("t4_arm_chg_cnt_next", 32'(cnt), 32'd0);

`ifdef QNET_DBG_TS_DELTA_EN
        // ---- delta timestamps: first entry 3 cycles after arm, next 5 apart ----
        do_arm();
        tick(); tick();
        push(6'd3, t_d1); tick();
        repeat (4) tick();
        push(6'd4, t_d2); tick();
        rd_idx = 4'd0; tick(); chk("td_first", rd_dt, {2'b00, 6'd3, 24'd3});
        rd_idx = 4'd1; tick(); chk("td_delta5", rd_dt, {2'b00, 6'd4, 24'd5});
`endif

        // ---- asynchronous reset mid-POST ----
        trig_en   = 1'b1;
        trig_code = CODE_ST_ERROR;
        do_arm();
        push(6'd63, t_tmp); tick();
        push(6'd1, t_tmp); tick();
        chk("t5_st_post", 32'(st), 32'(ST_POST));
        chk("t5_cnt2", 32'(cnt), 32'd2);
        rd_idx = 4'd0; tick();
        chk("t5_rd_nonzero", 32'(rd_dt != 32'h0), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_async_rd", rd_dt, 32'h0);
        chk("t5_async_cnt", 32'(cnt), 32'd0);
        chk("t5_async_st", 32'(st), 32'(ST_IDLE));
        chk("t5_async_trig", 32'(trig), 32'd0);
        chk("t5_async_wrap", 32'(wrap0 | wrap), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        push(6'd2, t_tmp); tick();
        push(6'd3, t_tmp); tick();
        chk("t5_idle_st", 32'(st), 32'(ST_IDLE));
        chk("t5_idle_cnt", 32'(cnt), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
